act_stream_unit: RTL

ACT_STREAM_UNIT -- requirements
Module: act_stream_unit

---
 rtl/act_stream_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/act_stream_unit.sv
// Streaming activation unit: LANES-wide per-element pass/ReLU/leaky/clipped-leaky
// with a two-stage valid/ready pipeline, guarded config load and a saturating beat counter.

module act_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [1:0]            mode,
  input  logic [3:0]            shift,
  input  logic [DATA_WIDTH-1:0] clip,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);
  logic signed [DATA_WIDTH-1:0] xs;
  logic signed [DATA_WIDTH-1:0] clip_eff;

  assign xs       = signed'(x);
  assign clip_eff = clip[DATA_WIDTH-1] ? '0 : signed'(clip);

  always_comb begin
    y = x;
    if (x[DATA_WIDTH-1]) begin
      if (mode == 2'd1)  y = '0;
      else if (mode[1])  y = xs >>> shift;
    end else if (mode == 2'd3 && xs > clip_eff) begin
      y = clip_eff;
    end
  end
endmodule

module act_stream_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  input  logic                        cfg_load,
  input  logic [1:0]                  cfg_mode,
  input  logic [3:0]                  cfg_shift,
  input  logic [DATA_WIDTH-1:0]       cfg_clip,
  output logic                        cfg_err,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        beat_cnt
);
  localparam int STAGES = 2;

  logic [STAGES:1]                        vld_pipe;
  logic [LANES-1:0][DATA_WIDTH-1:0]       lane_x;
  logic [LANES-1:0][DATA_WIDTH-1:0]       lane_y;
  logic [LANES*DATA_WIDTH-1:0]            s1_data;
  logic                                   s1_last;
  logic [1:0]                             mode_q;
  logic [3:0]                             shift_q;
  logic [DATA_WIDTH-1:0]                  clip_q;
  logic                                   s2_adv;
  logic                                   cfg_ok;
  logic                                   out_xfer;

  assign lane_x = in_data;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .mode (mode_q),
        .shift(shift_q),
        .clip (clip_q),
        .x    (lane_x[g]),
        .y    (lane_y[g])
      );
    end
  endgenerate

  assign out_valid = vld_pipe[2];
  assign out_xfer  = out_valid && out_ready;
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  // config may only change with nothing in flight and nothing being offered
  assign cfg_ok    = cfg_load && (vld_pipe == '0) && !in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      cfg_err  <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
      mode_q   <= 2'd2;
      shift_q  <= 4'd7;
      clip_q   <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_data <= lane_y;
          s1_last <= in_last;
        end
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data <= s1_data;
          out_last <= s1_last;
        end
      end
      cfg_err <= cfg_load && !cfg_ok;
      done    <= out_xfer && out_last;
      if (cfg_ok) begin
        mode_q   <= cfg_mode;
        shift_q  <= cfg_shift;
        clip_q   <= cfg_clip;
        beat_cnt <= '0;
      end else if (out_xfer && beat_cnt != {CNT_WIDTH{1'b1}}) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule
